// File: rtl/exec_unit_if.sv
// Request/result bundle between the issuing stage (master) and exec_unit (slave).
// Handshake: start is a request that is accepted only on a rising edge where the
// unit is idle (busy=0, done=0); it is dropped otherwise, and nothing queues. A
// result is valid for exactly the one cycle that done/reg_en are high.
interface exec_unit_if;
  logic              start;
  logic [2:0]        op;
  logic signed [7:0] opa;
  logic signed [7:0] opb;
  logic [1:0]        wb_in;
  logic              busy;
  logic              done;
  logic signed [7:0] data;
  logic [1:0]        wb;
  logic              reg_en;
  logic              zero;
  logic              ovf;
  logic [1:0]        dbg_state;

  modport master (
    output start, op, opa, opb, wb_in,
    input  busy, done, data, wb, reg_en, zero, ovf, dbg_state
  );

  modport slave (
    input  start, op, opa, opb, wb_in,
    output busy, done, data, wb, reg_en, zero, ovf, dbg_state
  );
endinterface

// File: rtl/exec_unit.sv
// Single-issue execution unit: one-cycle ALU ops and an 8-iteration
// shift-add signed multiplier, with a one-cycle register-file write-back pulse.
module exec_unit (
  input  logic        clk,
  input  logic        rst,
  exec_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t      state, state_nx;
  logic [7:0]  mag_a, mag_b;
  logic        neg_q;
  logic [1:0]  wb_q;
  logic [15:0] acc;
  logic [2:0]  cnt;

  logic        busy_r, done_r, reg_en_r, zero_r, ovf_r;
  logic [7:0]  data_r;
  logic [1:0]  wb_r;

  logic [7:0]  alu_res;
  logic        alu_ovf;
  logic [15:0] partial, acc_sum, prod;
  logic        mul_ovf;

  // Single-cycle ALU, evaluated straight off the request inputs.
  always_comb begin
    alu_res = 8'h00;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = bus.opa + bus.opb;
        alu_ovf = (bus.opa[7] == bus.opb[7]) && (alu_res[7] != bus.opa[7]);
      end
      OP_SUB: begin
        alu_res = bus.opa - bus.opb;
        alu_ovf = (bus.opa[7] != bus.opb[7]) && (alu_res[7] != bus.opa[7]);
      end
      OP_AND:  alu_res = bus.opa & bus.opb;
      OP_OR:   alu_res = bus.opa | bus.opb;
      OP_XOR:  alu_res = bus.opa ^ bus.opb;
      OP_SLL:  alu_res = bus.opa << bus.opb[2:0];
      OP_SRA:  alu_res = bus.opa >>> bus.opb[2:0];
      default: alu_res = 8'h00;
    endcase
  end

  // One multiplier iteration; prod is the sign-corrected value used on the last one.
  always_comb begin
    partial = mag_b[cnt] ? ({8'h00, mag_a} << cnt) : 16'h0000;
    acc_sum = acc + partial;
    prod    = neg_q ? (~acc_sum + 16'd1) : acc_sum;
    mul_ovf = (prod[15:7] != {9{prod[15]}});
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.op == OP_MUL) ? EXEC : WB;
      EXEC: if (cnt == 3'd7) state_nx = WB;
      WB:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      mag_a    <= 8'h00;
      mag_b    <= 8'h00;
      neg_q    <= 1'b0;
      wb_q     <= 2'd0;
      acc      <= 16'h0000;
      cnt      <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      reg_en_r <= 1'b0;
      data_r   <= 8'h00;
      wb_r     <= 2'd0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      busy_r   <= (state_nx != IDLE);
      done_r   <= (state_nx == WB);
      reg_en_r <= (state_nx == WB);
      case (state)
        IDLE: begin
          if (bus.start) begin
            mag_a <= bus.opa[7] ? (~bus.opa + 8'd1) : bus.opa;
            mag_b <= bus.opb[7] ? (~bus.opb + 8'd1) : bus.opb;
            neg_q <= bus.opa[7] ^ bus.opb[7];
            wb_q  <= bus.wb_in;
            acc   <= 16'h0000;
            cnt   <= 3'd0;
            if (bus.op != OP_MUL) begin
              data_r <= alu_res;
              zero_r <= (alu_res == 8'h00);
              ovf_r  <= alu_ovf;
              wb_r   <= bus.wb_in;
            end
          end
        end
        EXEC: begin
          acc <= acc_sum;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            data_r <= prod[7:0];
            zero_r <= (prod[7:0] == 8'h00);
            ovf_r  <= mul_ovf;
            wb_r   <= wb_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.reg_en    = reg_en_r;
  assign bus.data      = data_r;
  assign bus.wb        = wb_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed ALU/MUL vectors, latency,
// start-while-busy, back-to-back and mid-operation reset.
module tb_exec_unit;

  logic clk;
  logic rst;
  exec_unit_if bus ();

  exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.reg_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", 8'd1, 8'd0);
      else check("wr_data", bus.data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] w);
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    bus.wb_in = w;
  endtask

  task automatic scramble();
    bus.op    = 3'($urandom_range(0, 7));
    bus.opa   = 8'($urandom_range(0, 255));
    bus.opb   = 8'($urandom_range(0, 255));
    bus.wb_in = 2'($urandom_range(0, 3));
  endtask

  task automatic alu(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [1:0] w,
                     input logic [7:0] ed, input logic eo);
    @(negedge clk);
    drive(op, a, b, w);
    bus.start = 1'b1;
    exp_q.push_back(ed);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    check({tag, "_done"}, 8'(bus.done), 8'd1);
    check({tag, "_reg_en"}, 8'(bus.reg_en), 8'd1);
    check({tag, "_data"}, bus.data, ed);
    check({tag, "_ovf"}, 8'(bus.ovf), 8'(eo));
    check({tag, "_zero"}, 8'(bus.zero), 8'(ed == 8'h00));
    check({tag, "_wb"}, 8'(bus.wb), 8'(w));
    @(negedge clk);
    check({tag, "_done_drop"}, 8'(bus.done), 8'd0);
    check({tag, "_hold"}, bus.data, ed);
  endtask

  task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] w, input logic [7:0] ed, input logic eo,
                     input bit inject);
    int cyc;
    int wr0;
    wr0 = wr_cnt;
    @(negedge clk);
    drive(3'b111, a, b, w);
    bus.start = 1'b1;
    exp_q.push_back(ed);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    check({tag, "_busy1"}, 8'(bus.busy), 8'd1);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (inject && cyc == 3) begin
        drive(3'b000, 8'd1, 8'd1, 2'd0);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (bus.done !== 1'b1)
        check({tag, "_busy_exec"}, 8'(bus.busy), 8'd1);
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 8'(cyc), 8'd9);
    check({tag, "_data"}, bus.data, ed);
    check({tag, "_ovf"}, 8'(bus.ovf), 8'(eo));
    check({tag, "_wb"}, 8'(bus.wb), 8'(w));
    @(negedge clk);
    check({tag, "_busy_end"}, 8'(bus.busy), 8'd0);
    repeat (3) @(negedge clk);
    check({tag, "_one_write"}, 8'(wr_cnt - wr0), 8'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr0;
    rst = 1'b0;
    bus.start = 1'b1;
    drive(3'b000, 8'd3, 8'd4, 2'd1);
    repeat (3) @(negedge clk);
    check("rst_busy", 8'(bus.busy), 8'd0);
    check("rst_done", 8'(bus.done), 8'd0);
    check("rst_reg_en", 8'(bus.reg_en), 8'd0);
    check("rst_data", bus.data, 8'h00);
    check("rst_wb", 8'(bus.wb), 8'd0);
    check("rst_zero", 8'(bus.zero), 8'd0);
    check("rst_ovf", 8'(bus.ovf), 8'd0);
    check("rst_state", 8'(bus.dbg_state), 8'd0);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    alu("add_ovf",  3'b000, 8'd100, 8'd50, 2'd2, 8'h96, 1'b1);
    alu("sub_zero", 3'b001, 8'd5,   8'd5,  2'd1, 8'h00, 1'b0);
    alu("sra",      3'b110, 8'h80,  8'd3,  2'd0, 8'hF0, 1'b0);
    alu("sra_zero_amt", 3'b110, 8'h90, 8'h08, 2'd3, 8'h90, 1'b0);
    alu("sll",      3'b101, 8'h81,  8'd2,  2'd3, 8'h04, 1'b0);
    alu("sll_zero_amt", 3'b101, 8'h5A, 8'h08, 2'd2, 8'h5A, 1'b0);
    alu("and",      3'b010, 8'hA5,  8'h3C, 2'd1, 8'h24, 1'b0);
    alu("or",       3'b011, 8'hA5,  8'h3C, 2'd2, 8'hBD, 1'b0);
    alu("xor",      3'b100, 8'hA5,  8'h3C, 2'd0, 8'h99, 1'b0);
    alu("sub_ovf",  3'b001, 8'h80,  8'h01, 2'd1, 8'h7F, 1'b1);
    alu("add_wrap0", 3'b000, 8'h80, 8'h80, 2'd3, 8'h00, 1'b1);
    alu("add_neg",  3'b000, 8'hFD,  8'h01, 2'd0, 8'hFE, 1'b0);

    mul("mul_m7x9",   8'hF9, 8'd9,  2'd1, 8'hC1, 1'b0, 1'b0);
    mul("mul_m128xm1", 8'h80, 8'hFF, 2'd2, 8'h80, 1'b1, 1'b0);
    mul("mul_12x11",  8'd12, 8'd11, 2'd3, 8'h84, 1'b1, 1'b0);
    mul("mul_m1xm1",  8'hFF, 8'hFF, 2'd0, 8'h01, 1'b0, 1'b0);
    mul("mul_0xm5",   8'h00, 8'hFB, 2'd1, 8'h00, 1'b0, 1'b0);
    mul("mul_inject", 8'd3,  8'hFB, 2'd2, 8'hF1, 1'b0, 1'b1);

    // start held through the WB cycle: the second request lands one cycle later
    @(negedge clk);
    drive(3'b000, 8'd1, 8'd2, 2'd1);
    bus.start = 1'b1;
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd5);
    @(negedge clk);
    check("b2b_first", bus.data, 8'd3);
    drive(3'b001, 8'd7, 8'd2, 2'd2);
    @(negedge clk);
    check("b2b_wb_ignored_done", 8'(bus.done), 8'd0);
    check("b2b_wb_ignored_busy", 8'(bus.busy), 8'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_second_done", 8'(bus.done), 8'd1);
    check("b2b_second_data", bus.data, 8'd5);
    check("b2b_second_wb", 8'(bus.wb), 8'd2);
    @(negedge clk);

    // reset on the 4th EXEC edge aborts the multiply
    wr0 = wr_cnt;
    @(negedge clk);
    drive(3'b111, 8'd6, 8'd7, 2'd3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 8'(bus.busy), 8'd0);
    check("abort_data", bus.data, 8'h00);
    check("abort_state", 8'(bus.dbg_state), 8'd0);
    check("abort_wb", 8'(bus.wb), 8'd0);
    check("abort_flags", {6'd0, bus.zero, bus.ovf}, 8'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_write", 8'(wr_cnt - wr0), 8'd0);
    alu("after_abort", 3'b000, 8'd1, 8'd1, 2'd1, 8'd2, 1'b0);

    repeat (2) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
